// File: rtl/alu_result_stage.sv
// Registered result stage after the 16-bit ALU: derives zero/neg/jump at push,
// buffers entries in a small valid/ready FIFO and counts delivered results.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_lt,
    input  logic         in_eq,
    input  logic         in_gt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_zero,
    output logic         out_neg,
    output logic         out_jump,
    output logic [15:0]  res_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = W + 3;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry layout: {data, zero, neg, jump}
    logic [EW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [15:0]   res_count_reg;

    logic          push;
    logic          pop;
    logic          zero_next;
    logic          neg_next;
    logic          jump_next;
    logic [EW-1:0] entry_next;
    logic [EW-1:0] head;

    assign in_ready  = !rst && (count_reg != FULL_COUNT);
    assign out_valid = !rst && (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign zero_next  = (in_data == '0);
    assign neg_next   = in_data[W-1];
    assign jump_next  = (in_lt && neg_next) || (in_eq && zero_next) ||
                        (in_gt && !neg_next && !zero_next);
    assign entry_next = {in_data, zero_next, neg_next, jump_next};

    assign head = mem_reg[rd_ptr_reg];

    // Head fields are masked so an empty FIFO never exposes stale entries.
    assign out_data  = out_valid ? head[EW-1:3] : '0;
    assign out_zero  = out_valid & head[2];
    assign out_neg   = out_valid & head[1];
    assign out_jump  = out_valid & head[0];
    assign res_count = res_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr_reg == AW'(i)) begin
                    mem_reg[i] <= entry_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            res_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                res_count_reg <= res_count_reg + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
